// File: rtl/openram_tc_pkg.sv
// rtl/openram_tc_pkg.sv - shared widths, defaults and helpers for the OpenRAM testchip blocks
package openram_tc_pkg;

    localparam int RAM_DATA_WIDTH = 32;
    localparam int RAM_WMASK_WIDTH = 4;
    localparam logic [RAM_DATA_WIDTH-1:0] OOB_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic int sel_width(input int addr_w, input int bank_addr_w);
        return addr_w - bank_addr_w;
    endfunction

endpackage

// File: rtl/openram_bank_mux_sat_counter.sv
// rtl/openram_bank_mux_sat_counter.sv - saturating event counter, clear has priority over increment
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/openram_bank_mux.sv
// rtl/openram_bank_mux.sv - fans one SRAM port out to NUM_BANKS OpenRAM macros with debug counters/error capture
module openram_bank_mux
    import openram_tc_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH = 16,
    parameter logic [RAM_DATA_WIDTH-1:0] OOB_DATA = OOB_DATA_DEFAULT
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic                                up_csb,
    input  logic                                up_web,
    input  logic [RAM_WMASK_WIDTH-1:0]          up_wmask,
    input  logic [ADDR_WIDTH-1:0]               up_addr,
    input  logic [RAM_DATA_WIDTH-1:0]           up_wdata,
    output logic [RAM_DATA_WIDTH-1:0]           up_rdata,
    output logic                                bank_clk,
    output logic [NUM_BANKS-1:0]                bank_csb,
    output logic                                bank_web,
    output logic [RAM_WMASK_WIDTH-1:0]          bank_wmask,
    output logic [BANK_ADDR_WIDTH-1:0]          bank_addr,
    output logic [RAM_DATA_WIDTH-1:0]           bank_din,
    input  logic [NUM_BANKS*RAM_DATA_WIDTH-1:0] bank_dout,
    input  logic                                cnt_clr,
    output logic [NUM_BANKS*CNT_WIDTH-1:0]      bank_cnt,
    input  logic                                err_clr,
    output logic                                err_oob,
    output logic [ADDR_WIDTH-1:0]               err_addr
);

    localparam int SEL_WIDTH = sel_width(ADDR_WIDTH, BANK_ADDR_WIDTH);
    localparam int NUM_SLOTS = 1 << SEL_WIDTH;
    localparam logic [SEL_WIDTH:0] NUM_BANKS_L = (SEL_WIDTH+1)'(NUM_BANKS);

    logic [SEL_WIDTH-1:0]      sel;
    logic                      in_range;
    logic                      access;
    logic [SEL_WIDTH-1:0]      rd_sel_q, rd_sel_d;
    logic                      rd_oob_q, rd_oob_d;
    logic                      err_oob_q, err_oob_d;
    logic [ADDR_WIDTH-1:0]     err_addr_q, err_addr_d;
    logic [RAM_DATA_WIDTH-1:0] dout_arr [NUM_SLOTS];

    assign sel      = up_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    assign in_range = {1'b0, sel} < NUM_BANKS_L;
    assign access   = !up_csb && !wb_rst_i;

    assign bank_clk   = wb_clk_i;
    assign bank_web   = up_web;
    assign bank_wmask = up_wmask;
    assign bank_addr  = up_addr[BANK_ADDR_WIDTH-1:0];
    assign bank_din   = up_wdata;

    // Unpopulated select slots read as OOB_DATA so the mux index never leaves the array.
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        if (s < NUM_BANKS) begin : g_pop
            assign dout_arr[s] = bank_dout[s*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
        end else begin : g_empty
            assign dout_arr[s] = OOB_DATA;
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign bank_csb[i] = up_csb | wb_rst_i | (sel != SEL_WIDTH'(i));

        sat_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk_i(wb_clk_i),
            .rst_i(wb_rst_i),
            .inc_i(access && in_range && (sel == SEL_WIDTH'(i))),
            .clr_i(cnt_clr),
            .cnt_o(bank_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    always_comb begin
        rd_sel_d = rd_sel_q;
        rd_oob_d = rd_oob_q;
        if (access) begin
            rd_sel_d = sel;
            rd_oob_d = !in_range;
        end
    end

    // A clear in the same cycle as a new error still records the new error.
    always_comb begin
        err_oob_d  = err_oob_q;
        err_addr_d = err_addr_q;
        if (err_clr) begin
            err_oob_d  = 1'b0;
            err_addr_d = '0;
        end
        if (access && !in_range && (!err_oob_q || err_clr)) begin
            err_oob_d  = 1'b1;
            err_addr_d = up_addr;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_sel_q   <= '0;
            rd_oob_q   <= 1'b0;
            err_oob_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            rd_sel_q   <= rd_sel_d;
            rd_oob_q   <= rd_oob_d;
            err_oob_q  <= err_oob_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign up_rdata = rd_oob_q ? OOB_DATA : dout_arr[rd_sel_q];
    assign err_oob  = err_oob_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_openram_bank_mux.sv
// tb/tb_openram_bank_mux.sv - self-checking bench: 4-bank/16-bit and 3-bank/4-bit instances on shared upstream stimulus
module tb_openram_bank_mux;

    logic        clk = 1'b0;
    logic        rst, csb, web, cnt_clr, err_clr;
    logic [3:0]  wmask;
    logic [9:0]  addr;
    logic [31:0] wdata;

    logic [3:0]  csb_a;
    logic [2:0]  csb_b;
    logic        clk_a, clk_b, web_a, web_b, eoob_a, eoob_b;
    logic [3:0]  wm_a, wm_b;
    logic [7:0]  baddr_a, baddr_b;
    logic [31:0] din_a, din_b, rdata_a, rdata_b;
    logic [9:0]  eaddr_a, eaddr_b;
    logic [63:0] cnt_a;
    logic [11:0] cnt_b;
    logic [127:0] bdout_a;
    logic [95:0]  bdout_b;

    logic [31:0] dout_a [4];
    logic [31:0] dout_b [3];
    logic [31:0] mem_a [4][256];
    logic [31:0] mem_b [3][256];

    int n_tests = 0;
    int n_fail = 0;

    // reference model state
    int          cnt_ma [4];
    int          cnt_mb [3];
    bit          err_mb;
    logic [9:0]  eaddr_mb;
    bit          exp_va, exp_vb;
    logic [31:0] exp_ra, exp_rb;
    logic [31:0] shadow [int];

    always #5 clk = ~clk;

    assign bdout_a = {dout_a[3], dout_a[2], dout_a[1], dout_a[0]};
    assign bdout_b = {dout_b[2], dout_b[1], dout_b[0]};

    openram_bank_mux #(.NUM_BANKS(4), .BANK_ADDR_WIDTH(8), .ADDR_WIDTH(10), .CNT_WIDTH(16)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .up_csb(csb), .up_web(web), .up_wmask(wmask),
        .up_addr(addr), .up_wdata(wdata), .up_rdata(rdata_a), .bank_clk(clk_a),
        .bank_csb(csb_a), .bank_web(web_a), .bank_wmask(wm_a), .bank_addr(baddr_a),
        .bank_din(din_a), .bank_dout(bdout_a), .cnt_clr(cnt_clr), .bank_cnt(cnt_a),
        .err_clr(err_clr), .err_oob(eoob_a), .err_addr(eaddr_a)
    );

    openram_bank_mux #(.NUM_BANKS(3), .BANK_ADDR_WIDTH(8), .ADDR_WIDTH(10), .CNT_WIDTH(4)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .up_csb(csb), .up_web(web), .up_wmask(wmask),
        .up_addr(addr), .up_wdata(wdata), .up_rdata(rdata_b), .bank_clk(clk_b),
        .bank_csb(csb_b), .bank_web(web_b), .bank_wmask(wm_b), .bank_addr(baddr_b),
        .bank_din(din_b), .bank_dout(bdout_b), .cnt_clr(cnt_clr), .bank_cnt(cnt_b),
        .err_clr(err_clr), .err_oob(eoob_b), .err_addr(eaddr_b)
    );

    // OpenRAM-style macros: read data appears after the access edge and holds until the next read
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!csb_a[i]) begin
                if (web_a) dout_a[i] <= mem_a[i][baddr_a];
                else for (int b = 0; b < 4; b++)
                    if (wm_a[b]) mem_a[i][baddr_a][8*b +: 8] <= din_a[8*b +: 8];
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!csb_b[i]) begin
                if (web_b) dout_b[i] <= mem_b[i][baddr_b];
                else for (int b = 0; b < 4; b++)
                    if (wm_b[b]) mem_b[i][baddr_b][8*b +: 8] <= din_b[8*b +: 8];
            end
        end
    end

    function automatic void model_update();
        int s;
        logic [31:0] w;
        if (rst) begin
            foreach (cnt_ma[i]) cnt_ma[i] = 0;
            foreach (cnt_mb[i]) cnt_mb[i] = 0;
            err_mb = 0;
            eaddr_mb = '0;
            exp_va = 0;
            exp_vb = 0;
            return;
        end
        if (err_clr) begin
            err_mb = 0;
            eaddr_mb = '0;
        end
        if (!csb) begin
            s = int'(addr[9:8]);
            cnt_ma[s] = (cnt_ma[s] == 65535) ? 65535 : cnt_ma[s] + 1;
            exp_va = web && shadow.exists(int'(addr));
            if (exp_va) exp_ra = shadow[int'(addr)];
            if (s < 3) begin
                cnt_mb[s] = (cnt_mb[s] == 15) ? 15 : cnt_mb[s] + 1;
                exp_vb = exp_va;
                exp_rb = exp_ra;
            end else begin
                exp_vb = 1;
                exp_rb = 32'hDEAD_BEEF;
                if (!err_mb) begin
                    err_mb = 1;
                    eaddr_mb = addr;
                end
            end
            if (!web) begin
                if (shadow.exists(int'(addr))) begin
                    w = shadow[int'(addr)];
                    for (int b = 0; b < 4; b++) if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
                    shadow[int'(addr)] = w;
                end else if (wmask == 4'hF) begin
                    shadow[int'(addr)] = wdata;
                end
            end
        end
        if (cnt_clr) begin
            foreach (cnt_ma[i]) cnt_ma[i] = 0;
            foreach (cnt_mb[i]) cnt_mb[i] = 0;
        end
    endfunction

    task automatic set_in(input logic r, input logic c, input logic w, input logic [3:0] wm,
                          input logic [9:0] ad, input logic [31:0] wd, input logic cc, input logic ec);
        rst = r; csb = c; web = w; wmask = wm; addr = ad; wdata = wd; cnt_clr = cc; err_clr = ec;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 4'hF, 10'h105, 32'h5555_AAAA, 0, 0);
        #1;
        n_tests++;
        if (csb_a !== 4'hF || csb_b !== 3'h7) begin
            n_fail++; $display("FAIL reset_csb: got %h/%h expected f/7", csb_a, csb_b);
        end
        step();
        step();
        set_in(0, 1, 1, 4'hF, 10'h000, 32'h0, 0, 0);
        #1;
        n_tests++;
        if (cnt_a !== 64'h0 || cnt_b !== 12'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0/0", cnt_a, cnt_b);
        end
        n_tests++;
        if (eoob_a !== 1'b0 || eoob_b !== 1'b0 || eaddr_b !== 10'h0) begin
            n_fail++; $display("FAIL reset_err: got %b/%b/%h expected 0/0/0", eoob_a, eoob_b, eaddr_b);
        end
        n_tests++;
        if (rdata_a !== dout_a[0]) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected %h", rdata_a, dout_a[0]);
        end
    endtask

    task automatic test_basic();
        set_in(0, 0, 0, 4'hF, 10'h005, 32'h1111_1111, 0, 0);
        #1;
        n_tests++;
        if (csb_a !== 4'b1110) begin
            n_fail++; $display("FAIL basic_csb0: got %b expected 1110", csb_a);
        end
        step();
        set_in(0, 0, 0, 4'hF, 10'h105, 32'h2222_2222, 0, 0);
        #1;
        n_tests++;
        if (csb_a !== 4'b1101) begin
            n_fail++; $display("FAIL basic_csb1: got %b expected 1101", csb_a);
        end
        step();
        set_in(0, 0, 1, 4'hF, 10'h005, 32'h0, 0, 0);
        step();
        n_tests++;
        if (rdata_a !== 32'h1111_1111 || rdata_b !== 32'h1111_1111) begin
            n_fail++; $display("FAIL basic_rd0: got %h/%h expected 11111111", rdata_a, rdata_b);
        end
        set_in(0, 0, 1, 4'hF, 10'h105, 32'h0, 0, 0);
        step();
        n_tests++;
        if (rdata_a !== 32'h2222_2222) begin
            n_fail++; $display("FAIL basic_rd1: got %h expected 22222222", rdata_a);
        end
        n_tests++;
        if (cnt_a[15:0] !== 16'd2 || cnt_a[31:16] !== 16'd2) begin
            n_fail++; $display("FAIL basic_cnt: got %0d/%0d expected 2/2", cnt_a[15:0], cnt_a[31:16]);
        end
    endtask

    task automatic test_hold();
        set_in(0, 0, 0, 4'hF, 10'h305, 32'hCAFE_0003, 0, 0);
        step();
        set_in(0, 0, 1, 4'hF, 10'h305, 32'h0, 0, 0);
        step();
        set_in(0, 1, 1, 4'hF, 10'h005, 32'h0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (rdata_a !== 32'hCAFE_0003) begin
                n_fail++; $display("FAIL hold_rdata[%0d]: got %h expected cafe0003", k, rdata_a);
            end
            if (k < 3) step();
        end
        set_in(0, 0, 1, 4'hF, 10'h005, 32'h0, 0, 0);
        step();
        n_tests++;
        if (rdata_a !== 32'h1111_1111) begin
            n_fail++; $display("FAIL hold_next: got %h expected 11111111", rdata_a);
        end
    endtask

    task automatic test_oob();
        set_in(0, 1, 1, 4'hF, 10'h000, 32'h0, 0, 1);
        step();
        n_tests++;
        if (eoob_b !== 1'b0 || eaddr_b !== 10'h0) begin
            n_fail++; $display("FAIL oob_preclr: got %b/%h expected 0/000", eoob_b, eaddr_b);
        end
        set_in(0, 0, 1, 4'hF, 10'h3A0, 32'h0, 0, 0);
        #1;
        n_tests++;
        if (csb_b !== 3'b111) begin
            n_fail++; $display("FAIL oob_csb0: got %b expected 111", csb_b);
        end
        step();
        set_in(0, 0, 0, 4'hF, 10'h3FF, 32'h1234_5678, 0, 0);
        #1;
        n_tests++;
        if (csb_b !== 3'b111) begin
            n_fail++; $display("FAIL oob_csb1: got %b expected 111", csb_b);
        end
        step();
        n_tests++;
        if (rdata_b !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL oob_rdata: got %h expected deadbeef", rdata_b);
        end
        n_tests++;
        if (eoob_b !== 1'b1 || eaddr_b !== 10'h3A0) begin
            n_fail++; $display("FAIL oob_err: got %b/%h expected 1/3a0", eoob_b, eaddr_b);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (int'(cnt_b[i*4 +: 4]) != cnt_mb[i]) begin
                n_fail++; $display("FAIL oob_cnt[%0d]: got %0d expected %0d", i, cnt_b[i*4 +: 4], cnt_mb[i]);
            end
        end
    endtask

    task automatic test_err_clr();
        set_in(0, 0, 1, 4'hF, 10'h3C1, 32'h0, 0, 1);
        step();
        n_tests++;
        if (eoob_b !== 1'b1 || eaddr_b !== 10'h3C1) begin
            n_fail++; $display("FAIL errclr_set: got %b/%h expected 1/3c1", eoob_b, eaddr_b);
        end
        set_in(0, 1, 1, 4'hF, 10'h3C1, 32'h0, 0, 1);
        step();
        n_tests++;
        if (eoob_b !== 1'b0 || eaddr_b !== 10'h0) begin
            n_fail++; $display("FAIL errclr_clr: got %b/%h expected 0/000", eoob_b, eaddr_b);
        end
    endtask

    task automatic test_sat();
        set_in(0, 1, 1, 4'hF, 10'h0, 32'h0, 1, 0);
        step();
        for (int k = 0; k < 17; k++) begin
            set_in(0, 0, 1, 4'hF, 10'h210, 32'h0, 0, 0);
            step();
        end
        n_tests++;
        if (cnt_b[11:8] !== 4'hF) begin
            n_fail++; $display("FAIL sat_b2: got %h expected f", cnt_b[11:8]);
        end
        n_tests++;
        if (cnt_a[47:32] !== 16'd17) begin
            n_fail++; $display("FAIL sat_a2: got %0d expected 17", cnt_a[47:32]);
        end
        set_in(0, 0, 1, 4'hF, 10'h210, 32'h0, 1, 0);
        step();
        n_tests++;
        if (cnt_a !== 64'h0 || cnt_b !== 12'h0) begin
            n_fail++; $display("FAIL sat_clr: got %h/%h expected 0/0", cnt_a, cnt_b);
        end
    endtask

    task automatic test_random();
        logic        c, w, cc, ec;
        logic [3:0]  wm, ecsb_a;
        logic [2:0]  ecsb_b;
        logic [9:0]  ad;
        logic [31:0] wd;
        for (int n = 0; n < 300; n++) begin
            c  = ($urandom_range(0, 4) == 0);
            w  = 1'($urandom_range(0, 1));
            wm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            ad = {2'($urandom), 5'b0, 3'($urandom)};
            wd = $urandom;
            cc = ($urandom_range(0, 40) == 0);
            ec = ($urandom_range(0, 20) == 0);
            set_in(0, c, w, wm, ad, wd, cc, ec);
            #1;
            ecsb_a = c ? 4'hF : ~(4'b0001 << ad[9:8]);
            ecsb_b = (c || ad[9:8] == 2'd3) ? 3'h7 : ~(3'b001 << ad[9:8]);
            n_tests++;
            if (csb_a !== ecsb_a || csb_b !== ecsb_b) begin
                n_fail++; $display("FAIL rnd_csb[%0d]: got %b/%b expected %b/%b", n, csb_a, csb_b, ecsb_a, ecsb_b);
            end
            n_tests++;
            if (baddr_a !== ad[7:0] || din_b !== wd || web_a !== w || wm_b !== wm) begin
                n_fail++; $display("FAIL rnd_bcast[%0d]: got %h/%h/%b/%h expected %h/%h/%b/%h",
                                   n, baddr_a, din_b, web_a, wm_b, ad[7:0], wd, w, wm);
            end
            step();
            if (exp_va) begin
                n_tests++;
                if (rdata_a !== exp_ra) begin
                    n_fail++; $display("FAIL rnd_rdata_a[%0d]: got %h expected %h", n, rdata_a, exp_ra);
                end
            end
            if (exp_vb) begin
                n_tests++;
                if (rdata_b !== exp_rb) begin
                    n_fail++; $display("FAIL rnd_rdata_b[%0d]: got %h expected %h", n, rdata_b, exp_rb);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (int'(cnt_a[i*16 +: 16]) != cnt_ma[i] || (i < 3 && int'(cnt_b[i*4 +: 4]) != cnt_mb[i])) begin
                    n_fail++; $display("FAIL rnd_cnt[%0d][%0d]: got %0d/%0d expected %0d/%0d", n, i,
                                       cnt_a[i*16 +: 16], (i < 3) ? int'(cnt_b[i*4 +: 4]) : 0,
                                       cnt_ma[i], (i < 3) ? cnt_mb[i] : 0);
                end
            end
            n_tests++;
            if (eoob_a !== 1'b0 || eoob_b !== err_mb || eaddr_b !== eaddr_mb) begin
                n_fail++; $display("FAIL rnd_err[%0d]: got %b/%b/%h expected 0/%b/%h", n, eoob_a, eoob_b, eaddr_b, err_mb, eaddr_mb);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_in(0, 0, 1, 4'hF, 10'h305, 32'h0, 0, 0);
        step();
        set_in(1, 0, 0, 4'hF, 10'h1AA, 32'h7777_7777, 0, 0);
        #1;
        n_tests++;
        if (csb_a !== 4'hF || csb_b !== 3'h7) begin
            n_fail++; $display("FAIL rstmid_csb: got %b/%b expected 1111/111", csb_a, csb_b);
        end
        step();
        set_in(0, 1, 1, 4'hF, 10'h0, 32'h0, 0, 0);
        #1;
        n_tests++;
        if (rdata_a !== dout_a[0] || rdata_b !== dout_b[0]) begin
            n_fail++; $display("FAIL rstmid_rdsel: got %h/%h expected %h/%h", rdata_a, rdata_b, dout_a[0], dout_b[0]);
        end
        n_tests++;
        if (cnt_a !== 64'h0 || cnt_b !== 12'h0 || eoob_b !== 1'b0 || eaddr_b !== 10'h0) begin
            n_fail++; $display("FAIL rstmid_state: got %h/%h/%b/%h expected 0/0/0/0", cnt_a, cnt_b, eoob_b, eaddr_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_oob();
        test_err_clr();
        test_sat();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/openram_bank_mux.md
Name: openram_bank_mux

Overview:
Downstream neighbour of the Wishbone-to-OpenRAM bridge. It takes the bridge's single RW SRAM port, which has a wide address, and fans it out to NUM_BANKS OpenRAM macros by decoding the upper address bits. It steers read data back through a bank index registered at access time. It also keeps per-bank saturating access counters and a sticky out-of-range error with the captured address, for bring-up and debug on the testchip.

Parameters:
NUM_BANKS, 4, number of attached macros; legal range 1..2**SEL_WIDTH.
BANK_ADDR_WIDTH, 8, word-address width of each macro.
ADDR_WIDTH, 10, upstream address width; SEL_WIDTH = ADDR_WIDTH-BANK_ADDR_WIDTH, must be >=1.
CNT_WIDTH, 16, width of each per-bank access counter.
OOB_DATA, 32'hDEAD_BEEF, read data returned for an out-of-range bank.

Ports:
wb_clk_i  in  1  clock; also drives the macro clocks.
wb_rst_i  in  1  reset; synchronous, active-high.
up_csb  in  1  active-low chip select from the bridge.
up_web  in  1  active-low write enable.
up_wmask  in  4  byte write mask.
up_addr  in  ADDR_WIDTH  word address; bits [ADDR_WIDTH-1:BANK_ADDR_WIDTH] are the bank select.
up_wdata  in  32  write data.
up_rdata  out  32  read data returned to the bridge.
bank_clk  out  1  equal to wb_clk_i.
bank_csb  out  NUM_BANKS  per-macro active-low chip select.
bank_web  out  1  broadcast of up_web.
bank_wmask  out  4  broadcast of up_wmask.
bank_addr  out  BANK_ADDR_WIDTH  equal to up_addr[BANK_ADDR_WIDTH-1:0].
bank_din  out  32  broadcast of up_wdata.
bank_dout  in  NUM_BANKS*32  macro read data; bank i occupies bits [32i+31:32i].
cnt_clr  in  1  synchronous clear of all counters.
bank_cnt  out  NUM_BANKS*CNT_WIDTH  per-bank access counts, packed the same way as bank_dout.
err_clr  in  1  clears the sticky error.
err_oob  out  1  sticky flag: an out-of-range access occurred.
err_addr  out  ADDR_WIDTH  up_addr of the first out-of-range access since the last clear.

Behaviour:
- Clock and reset: one clock, wb_clk_i; all state changes on its posedge; reset is synchronous and active-high.
- Access definition: an access is a posedge at which up_csb==0 and wb_rst_i==0.
- Bank decode: sel = up_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH].
  - in_range when sel < NUM_BANKS.
  - bank_csb[i] = up_csb | wb_rst_i | (sel != i), combinational.
  - An out-of-range sel drives every bank_csb high.
- Broadcast outputs: bank_web, bank_wmask, bank_addr, bank_din are combinational pass-throughs with no added latency. The macros sample them on the same posedge as the access.
- Read steering state: rd_sel (SEL_WIDTH) and rd_oob (1).
  - Both load on every access, read or write: rd_sel<=sel, rd_oob<=!in_range.
  - Both hold between accesses.
- Read data: up_rdata = rd_oob ? OOB_DATA : bank_dout[rd_sel], combinational from registered state.
  - Data is valid from the posedge of the access until the next access. This covers the bridge's negedge ack sample.
- Counters:
  - On each in-range access, bank_cnt[sel] increments by 1 and saturates at all-ones; there is no wrap.
  - Out-of-range accesses count nowhere.
  - cnt_clr zeroes all counters; when it coincides with an access, clear wins and the result is 0.
- Error capture:
  - On an out-of-range access with err_oob==0: err_oob<=1, err_addr<=up_addr.
  - Further out-of-range accesses do not overwrite err_addr.
  - err_clr zeroes err_oob and err_addr. When err_clr coincides with an out-of-range access, the new error is captured (set wins), so errors are never lost.
- Reset values: rd_sel=0, rd_oob=0, all counters 0, err_oob=0, err_addr=0, all bank_csb high. After reset, up_rdata = bank_dout[0].
- Reset mid-access: bank_csb is forced high in that cycle. No counter, rd_sel or error update occurs.
- NUM_BANKS == 2**SEL_WIDTH: out-of-range is impossible; the error logic is constant 0 and may be optimised away.

Decomposition:
- Shared package openram_tc_pkg: RAM_DATA_WIDTH=32, RAM_WMASK_WIDTH=4, OOB_DATA default, and a sel_width(addr_w, bank_addr_w) function.
- One sub-module, sat_counter (CNT_WIDTH, inc, clr, synchronous reset, clear-over-increment priority), instantiated NUM_BANKS times.
- The mux, decode and error logic stay in the top module.

Test Plan:
1. Write 32'h1111_1111 at addr 0x005 and 32'h2222_2222 at 0x105, then read both -> bank_csb==4'b1110 on the first write and 4'b1101 on the second; reads return the written values; bank_cnt[0]==2, bank_cnt[1]==2.
2. Read 0x305, then idle 3 cycles with bank_dout[3]=32'hCAFE_0003 -> up_rdata==32'hCAFE_0003 from the access posedge through all idle cycles; it changes only at the next access.
3. NUM_BANKS=3, access 0x3A0 then 0x3FF -> all bank_csb high; up_rdata==32'hDEAD_BEEF; err_oob==1; err_addr==0x3A0; no counter changes.
4. Assert err_clr in the same cycle as an out-of-range access to 0x3C1 -> err_oob stays 1 and err_addr==0x3C1. A later err_clr with no access -> err_oob==0, err_addr==0.
5. CNT_WIDTH=4: 17 accesses to bank 2 -> bank_cnt[2]==4'hF. Then cnt_clr together with an access -> all counters 0.
6. Assert wb_rst_i while up_csb==0 targeting bank 1 -> bank_csb all high; rd_sel==0; counters and error at reset values on the next cycle.
